// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encodings, direction constants and score width.
// Used by the game controller, the ball mover and the score display.
package pong_pkg;

    localparam int SCORE_W = 4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] score,
                                                   input logic [SCORE_W-1:0] limit);
        return (score >= limit) ? score : score + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Counts frame pulses while a serve is pending; done fires combinationally on the
// SERVE_FRAMES-th pulse so the caller can leave SERVE on that same clock edge.
module pong_serve_timer #(
    parameter int SERVE_FRAMES = 60
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clear,
    input  logic frame,
    output logic done
);

    localparam logic [7:0] LAST = 8'(SERVE_FRAMES - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst_l || clear) begin
            count <= 8'd0;
        end else if (frame) begin
            count <= count + 8'd1;
        end
    end

    assign done = frame && !clear && (count == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, ball direction, scoring and win detection.
// Define PONG_DIR_OVERRIDE_EN to let debug switches override direction during play.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Frame,
    input  logic               i_Start,
    input  logic               i_Top_Hit,
    input  logic               i_Bottom_Hit,
    input  logic               i_Paddle1_Hit,
    input  logic               i_Paddle2_Hit,
    input  logic               i_Left_Miss,
    input  logic               i_Right_Miss,
    input  logic               i_Switch_1,
    input  logic               i_Switch_2,
    input  logic               i_Switch_3,
    input  logic               i_Switch_4,
    output logic               o_HDir,
    output logic               o_VDir,
    output logic               o_Ball_En,
    output logic               o_Ball_Center,
    output logic [SCORE_W-1:0] o_Score1,
    output logic [SCORE_W-1:0] o_Score2,
    output logic               o_Game_Over,
    output logic [2:0]         o_State
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_t state;
    logic   start_r, start_q;
    logic   serve_dir;
    logic   serve_done;
    logic   start_edge;
    logic   win;
    logic   enter_serve;
    logic   play_h, play_v;

    assign o_State    = state;
    assign start_edge = start_r && !start_q;
    assign win        = (o_Score1 == WIN) || (o_Score2 == WIN);

    // A new game starts from IDLE/OVER; a finished point re-serves unless someone won.
    assign enter_serve = (((state == ST_IDLE) || (state == ST_OVER)) && start_edge)
                      || ((state == ST_POINT) && !win);

    pong_serve_timer #(.SERVE_FRAMES(SERVE_FRAMES)) u_serve_timer (
        .clk   (i_Clk),
        .rst_l (i_Rst_L),
        .clear (state != ST_SERVE),
        .frame (i_Frame),
        .done  (serve_done)
    );

    always_comb begin
        play_h = o_HDir;
        play_v = o_VDir;
        if (i_Paddle1_Hit) begin
            play_h = DIR_RIGHT;
        end else if (i_Paddle2_Hit) begin
            play_h = DIR_LEFT;
        end
        if (i_Top_Hit && !i_Bottom_Hit) begin
            play_v = DIR_DOWN;
        end else if (i_Bottom_Hit && !i_Top_Hit) begin
            play_v = DIR_UP;
        end
`ifdef PONG_DIR_OVERRIDE_EN
        if (i_Switch_4) begin
            play_h = DIR_RIGHT;
            play_v = DIR_DOWN;
        end else if (i_Switch_3) begin
            play_h = DIR_RIGHT;
            play_v = DIR_UP;
        end else if (i_Switch_2) begin
            play_h = DIR_LEFT;
            play_v = DIR_DOWN;
        end else if (i_Switch_1) begin
            play_h = DIR_LEFT;
            play_v = DIR_UP;
        end
`endif
    end

`ifndef PONG_DIR_OVERRIDE_EN
    logic unused_switches;
    assign unused_switches = ^{i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4};
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state         <= ST_IDLE;
            start_r       <= 1'b0;
            start_q       <= 1'b0;
            serve_dir     <= DIR_RIGHT;
            o_HDir        <= DIR_RIGHT;
            o_VDir        <= DIR_UP;
            o_Ball_En     <= 1'b0;
            o_Ball_Center <= 1'b1;
            o_Score1      <= '0;
            o_Score2      <= '0;
            o_Game_Over   <= 1'b0;
        end else begin
            start_r <= i_Start;
            start_q <= start_r;

            case (state)
                ST_SERVE: begin
                    if (serve_done) begin
                        state         <= ST_PLAY;
                        o_Ball_En     <= 1'b1;
                        o_Ball_Center <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (i_Left_Miss) begin
                        o_Score2      <= sat_inc(o_Score2, WIN);
                        serve_dir     <= DIR_LEFT;
                        state         <= ST_POINT;
                        o_Ball_En     <= 1'b0;
                        o_Ball_Center <= 1'b1;
                    end else if (i_Right_Miss) begin
                        o_Score1      <= sat_inc(o_Score1, WIN);
                        serve_dir     <= DIR_RIGHT;
                        state         <= ST_POINT;
                        o_Ball_En     <= 1'b0;
                        o_Ball_Center <= 1'b1;
                    end else begin
                        o_HDir <= play_h;
                        o_VDir <= play_v;
                    end
                end
                ST_POINT: begin
                    if (win) begin
                        state       <= ST_OVER;
                        o_Game_Over <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (enter_serve) begin
                state         <= ST_SERVE;
                o_HDir        <= (state == ST_POINT) ? serve_dir : DIR_RIGHT;
                o_VDir        <= ~o_VDir;
                o_Ball_En     <= 1'b0;
                o_Ball_Center <= 1'b1;
                o_Game_Over   <= 1'b0;
                if (state != ST_POINT) begin
                    o_Score1 <= '0;
                    o_Score2 <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl with SERVE_FRAMES=3, WIN_SCORE=2.
module tb_pong_game_ctrl;

    localparam int SF = 3;
    localparam int WS = 2;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       frame, start, top, bottom, pad1, pad2, lmiss, rmiss;
    logic       sw1, sw2, sw3, sw4;
    logic       hdir, vdir, ball_en, ball_center, game_over;
    logic [3:0] score1, score2;
    logic [2:0] state;

    // expected outputs after the next clock edge
    logic [2:0] e_st;
    logic       e_h, e_v, e_en, e_c, e_go;
    logic [3:0] e_s1, e_s2;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(.SERVE_FRAMES(SF), .WIN_SCORE(WS)) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Frame(frame), .i_Start(start),
        .i_Top_Hit(top), .i_Bottom_Hit(bottom),
        .i_Paddle1_Hit(pad1), .i_Paddle2_Hit(pad2),
        .i_Left_Miss(lmiss), .i_Right_Miss(rmiss),
        .i_Switch_1(sw1), .i_Switch_2(sw2), .i_Switch_3(sw3), .i_Switch_4(sw4),
        .o_HDir(hdir), .o_VDir(vdir), .o_Ball_En(ball_en), .o_Ball_Center(ball_center),
        .o_Score1(score1), .o_Score2(score2), .o_Game_Over(game_over), .o_State(state)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got st=%0d h=%b v=%b en=%b c=%b s1=%0d s2=%0d go=%b, expected st=%0d h=%b v=%b en=%b c=%b s1=%0d s2=%0d go=%b",
                     tag, got[15:13], got[12], got[11], got[10], got[9], got[8:5], got[4:1], got[0],
                     exp[15:13], exp[12], exp[11], exp[10], exp[9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    // Push the expectation, clock once, then compare against what the DUT produced.
    task automatic cycle(input string tag);
        exp_q.push_back({e_st, e_h, e_v, e_en, e_c, e_s1, e_s2, e_go});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(),
              {state, hdir, vdir, ball_en, ball_center, score1, score2, game_over},
              exp_q.pop_front());
    endtask

    task automatic clear_flags();
        frame = 0; top = 0; bottom = 0; pad1 = 0; pad2 = 0; lmiss = 0; rmiss = 0;
        sw1 = 0; sw2 = 0; sw3 = 0; sw4 = 0;
    endtask

    task automatic expect_reset();
        e_st = 3'd0; e_h = 1'b0; e_v = 1'b1; e_en = 1'b0; e_c = 1'b1;
        e_s1 = 4'd0; e_s2 = 4'd0; e_go = 1'b0;
    endtask

    // SF frame pulses with random idle gaps; state moves to PLAY on the last pulse.
    task automatic serve_to_play();
        for (int k = 1; k <= SF; k++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cycle("serve_gap");
            frame = 1;
            if (k == SF) begin
                e_st = 3'd2; e_en = 1'b1; e_c = 1'b0;
            end
            cycle((k == SF) ? "serve_to_play" : "serve_frame");
            frame = 0;
        end
    endtask

    // Start press from a released button: one cycle of edge-detect delay, then SERVE.
    task automatic press_start(input logic new_v);
        start = 1;
        cycle("start_latency");
        e_st = 3'd1; e_h = 1'b0; e_v = new_v; e_en = 1'b0; e_c = 1'b1;
        e_s1 = 4'd0; e_s2 = 4'd0; e_go = 1'b0;
        cycle("start_serve");
    endtask

    initial begin
        clear_flags();
        start = 0;
        rst_l = 0;
        expect_reset();
        cycle("reset_0");
        cycle("reset_1");
        rst_l = 1;
        cycle("idle");
        frame = 1; cycle("idle_frame_ignored");
        frame = 0; cycle("idle_gap");
        frame = 1; cycle("idle_frame_ignored2");
        frame = 0;

        press_start(1'b0);
        serve_to_play();

        pad2 = 1; e_h = 1'b1; cycle("paddle2");
        cycle("paddle2_held");
        pad2 = 0;
        bottom = 1; e_v = 1'b1; cycle("bottom");
        top = 1; cycle("both_walls_hold");
        bottom = 0; e_v = 1'b0; cycle("top");
        top = 0; bottom = 1; pad1 = 1; e_h = 1'b0; e_v = 1'b1; cycle("p1_bottom");
        bottom = 0; pad1 = 0;
        top = 1; bottom = 1; cycle("both_walls");
        top = 0; bottom = 0;

        lmiss = 1; rmiss = 1;
        e_st = 3'd3; e_s2 = 4'd1; e_en = 1'b0; e_c = 1'b1;
        cycle("double_miss");
        lmiss = 0; rmiss = 0;
        e_st = 3'd1; e_h = 1'b1; e_v = 1'b0;
        cycle("point_one_cycle");
        serve_to_play();

        rmiss = 1; pad1 = 1;
        e_st = 3'd3; e_s1 = 4'd1; e_en = 1'b0; e_c = 1'b1;
        cycle("rmiss_suppresses_paddle");
        rmiss = 0; pad1 = 0;
        e_st = 3'd1; e_h = 1'b0; e_v = 1'b1;
        cycle("serve_toward_right");
        serve_to_play();

        rmiss = 1;
        e_st = 3'd3; e_s1 = 4'd2; e_en = 1'b0; e_c = 1'b1;
        cycle("rmiss_win");
        rmiss = 0;
        e_st = 3'd4; e_go = 1'b1;
        cycle("over");
        rmiss = 1; cycle("over_miss_ignored");
        rmiss = 0;
        for (int i = 0; i < 3; i++) cycle("over_start_held");

        start = 0; cycle("over_release");
        cycle("over_released");
        press_start(1'b0);
        serve_to_play();

        rmiss = 1;
        e_st = 3'd3; e_s1 = 4'd1; e_en = 1'b0; e_c = 1'b1;
        cycle("rmiss_again");
        rmiss = 0;
        e_st = 3'd1; e_h = 1'b0; e_v = 1'b1;
        cycle("serve_again");
        serve_to_play();

        start = 0;
        rst_l = 0;
        expect_reset();
        cycle("mid_play_reset");
        rst_l = 1;
        cycle("after_reset_idle");

`ifdef PONG_DIR_OVERRIDE_EN
        press_start(1'b0);
        serve_to_play();
        sw4 = 1; pad2 = 1; bottom = 1; e_h = 1'b0; e_v = 1'b0;
        cycle("switch4_override");
        sw4 = 0; pad2 = 0; bottom = 0;
        sw1 = 1; e_h = 1'b1; e_v = 1'b1;
        cycle("switch1_override");
        sw1 = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
